// File: rtl/mem_wb_arbiter.sv
// mem_wb_arbiter
// Shares one memory-map slave port (RAM/ROM/video) between two masters:
// master 0 (CPU) and master 1 (DMA / test sequencer). One master is granted
// at a time and the grant is held until the slave acks, the master drops its
// strobe, or the bus watchdog expires. A watchdog expiry returns a one-cycle
// error pulse to the granted master so that a stalled slave cannot hang the
// system. Every transaction is followed by at least one IDLE cycle.
//
// Parameters
//   PRIORITY  : 0 = round-robin, 1 = master 0 wins simultaneous requests
//   TO_CYCLES : BUSY cycles allowed without a slave ack (1..2^TO_W-1)
//   TO_W      : watchdog counter width
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   mK_adr_i/dat_i/we_i/     : master K request (20-bit byte address,
//   mK_byte_i/stb_i            16-bit write data, write, byte select, strobe)
//   mK_ack_o, mK_err_o       : master K acknowledge / timeout error pulse
//   m_dat_o                  : read data to both masters (copy of s_dat_i)
//   s_adr_o/dat_o/we_o/      : slave request, copied from the granted master
//   s_byte_o/stb_o
//   s_dat_i, s_ack_i         : slave read data and acknowledge
//   gnt_o                    : one-hot current grant, 00 when idle
module mem_wb_arbiter #(
    parameter int PRIORITY  = 0,
    parameter int TO_CYCLES = 255,
    parameter int TO_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] m0_adr_i,
    input  logic [15:0] m0_dat_i,
    input  logic        m0_we_i,
    input  logic        m0_byte_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [19:0] m1_adr_i,
    input  logic [15:0] m1_dat_i,
    input  logic        m1_we_i,
    input  logic        m1_byte_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [15:0] m_dat_o,
    output logic [19:0] s_adr_o,
    output logic [15:0] s_dat_o,
    output logic        s_we_o,
    output logic        s_byte_o,
    output logic        s_stb_o,
    input  logic [15:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TO_CYCLES - 1);

    state_t          state_q, state_d;
    logic            last_q, last_d;
    logic [TO_W-1:0] wd_q, wd_d;

    logic wd_expired;
    logic busy0;
    logic busy1;

    // Next-state logic: arbitration in IDLE, exit conditions in BUSYk.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        wd_d       = wd_q;
        wd_expired = (wd_q == WD_LAST);
        case (state_q)
            IDLE: begin
                if (m0_stb_i && m1_stb_i) begin
                    // last_q==1 means master 1 was served most recently, so
                    // master 0 is next in the round-robin order.
                    if ((PRIORITY != 0) || last_q) begin
                        state_d = BUSY0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = BUSY1;
                        last_d  = 1'b1;
                    end
                    wd_d = '0;
                end else if (m0_stb_i) begin
                    state_d = BUSY0;
                    last_d  = 1'b0;
                    wd_d    = '0;
                end else if (m1_stb_i) begin
                    state_d = BUSY1;
                    last_d  = 1'b1;
                    wd_d    = '0;
                end
            end
            BUSY0: begin
                if (s_ack_i || !m0_stb_i || wd_expired) begin
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            BUSY1: begin
                if (s_ack_i || !m1_stb_i || wd_expired) begin
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    // Output steering. Reset gates the grant immediately so that a
    // transaction interrupted by rst never produces an ack or error.
    always_comb begin
        busy0 = (state_q == BUSY0) && !rst;
        busy1 = (state_q == BUSY1) && !rst;

        // Master 0 is the default source; the other master's request is only
        // ever steered to the slave while it holds the grant.
        s_adr_o  = busy1 ? m1_adr_i  : m0_adr_i;
        s_dat_o  = busy1 ? m1_dat_i  : m0_dat_i;
        s_byte_o = busy1 ? m1_byte_i : m0_byte_i;
        s_we_o   = (busy0 && m0_we_i) || (busy1 && m1_we_i);
        s_stb_o  = (busy0 && m0_stb_i) || (busy1 && m1_stb_i);

        m0_ack_o = busy0 && s_ack_i;
        m1_ack_o = busy1 && s_ack_i;

        // An ack in the expiry cycle wins over the timeout.
        m0_err_o = busy0 && m0_stb_i && !s_ack_i && wd_expired;
        m1_err_o = busy1 && m1_stb_i && !s_ack_i && wd_expired;

        gnt_o   = {busy1, busy0};
        m_dat_o = s_dat_i;
    end

endmodule

// File: tb/tb_mem_wb_arbiter.sv
module tb_mem_wb_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] m0_adr, m1_adr;
    logic [15:0] m0_dat, m1_dat;
    logic        m0_we, m0_byte, m0_stb;
    logic        m1_we, m1_byte, m1_stb;
    logic [15:0] s_dat_in;
    logic        s_ack_rr, s_ack_fp;

    // round-robin instance outputs
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [15:0] m_dat, s_dat;
    logic [19:0] s_adr;
    logic        s_we, s_byte, s_stb;
    logic [1:0]  gnt;

    // fixed-priority instance outputs
    logic        fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err;
    logic [15:0] fp_m_dat, fp_s_dat;
    logic [19:0] fp_s_adr;
    logic        fp_s_we, fp_s_byte, fp_s_stb;
    logic [1:0]  fp_gnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_wb_arbiter #(.PRIORITY(0), .TO_CYCLES(TO), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we), .m0_byte_i(m0_byte),
        .m0_stb_i(m0_stb), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we), .m1_byte_i(m1_byte),
        .m1_stb_i(m1_stb), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .m_dat_o(m_dat), .s_adr_o(s_adr), .s_dat_o(s_dat), .s_we_o(s_we),
        .s_byte_o(s_byte), .s_stb_o(s_stb), .s_dat_i(s_dat_in), .s_ack_i(s_ack_rr),
        .gnt_o(gnt)
    );

    mem_wb_arbiter #(.PRIORITY(1), .TO_CYCLES(TO), .TO_W(8)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we), .m0_byte_i(m0_byte),
        .m0_stb_i(m0_stb), .m0_ack_o(fp_m0_ack), .m0_err_o(fp_m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we), .m1_byte_i(m1_byte),
        .m1_stb_i(m1_stb), .m1_ack_o(fp_m1_ack), .m1_err_o(fp_m1_err),
        .m_dat_o(fp_m_dat), .s_adr_o(fp_s_adr), .s_dat_o(fp_s_dat), .s_we_o(fp_s_we),
        .s_byte_o(fp_s_byte), .s_stb_o(fp_s_stb), .s_dat_i(s_dat_in), .s_ack_i(s_ack_fp),
        .gnt_o(fp_gnt)
    );

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_adr = '0; m0_dat = '0; m0_we = 1'b0; m0_byte = 1'b0; m0_stb = 1'b0;
        m1_adr = '0; m1_dat = '0; m1_we = 1'b0; m1_byte = 1'b0; m1_stb = 1'b0;
        s_dat_in = '0; s_ack_rr = 1'b0; s_ack_fp = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        m0_stb = 1'b1;
        m1_stb = 1'b1;
        s_ack_rr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({gnt, s_stb, s_we, m0_ack, m1_ack, m0_err, m1_err} !== 7'b0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got=%b exp=0000000", i,
                         {gnt, s_stb, s_we, m0_ack, m1_ack, m0_err, m1_err});
            end
            cyc();
        end
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({gnt, s_stb} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=000", {gnt, s_stb});
        end
        cyc();
    endtask

    task automatic test_single_read();
        int stb_cycles;
        int ack_cycles;
        logic [1:0] expg;
        do_reset();
        m1_adr = 20'h5A5A5; m1_dat = 16'hBEEF; m1_we = 1'b1;
        m0_adr = 20'hC0004; m0_we = 1'b0; m0_byte = 1'b0; m0_stb = 1'b1;
        stb_cycles = 0;
        ack_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                s_ack_rr = 1'b1;
                s_dat_in = 16'h0A0B;
            end
            @(negedge clk);
            if (s_stb === 1'b1) stb_cycles++;
            if (m0_ack === 1'b1) begin
                ack_cycles++;
                checks++;
                if (m_dat !== 16'h0A0B) begin
                    failures++;
                    $display("FAIL read_data got=%h exp=0a0b", m_dat);
                end
            end
            expg = (i >= 1 && i <= 3) ? 2'b01 : 2'b00;
            checks++;
            if ({gnt, m1_ack} !== {expg, 1'b0}) begin
                failures++;
                $display("FAIL read_gnt cyc=%0d got=%b exp=%b", i, {gnt, m1_ack}, {expg, 1'b0});
            end
            if (expg == 2'b01) begin
                checks++;
                if ({s_adr, s_we} !== {20'hC0004, 1'b0}) begin
                    failures++;
                    $display("FAIL read_adr cyc=%0d got=%h exp=%h", i, {s_adr, s_we}, {20'hC0004, 1'b0});
                end
            end
            cyc();
            if (i == 3) begin
                m0_stb = 1'b0;
                s_ack_rr = 1'b0;
            end
        end
        checks++;
        if (stb_cycles != 3) begin
            failures++;
            $display("FAIL read_stb_len got=%0d exp=3", stb_cycles);
        end
        checks++;
        if (ack_cycles != 1) begin
            failures++;
            $display("FAIL read_ack_len got=%0d exp=1", ack_cycles);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_rr [8];
        logic [1:0] exp_fp [8];
        exp_rr = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        exp_fp = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
        do_reset();
        m0_adr = 20'h01234; m0_dat = 16'h7777; m0_we = 1'b0; m0_byte = 1'b0; m0_stb = 1'b1;
        m1_adr = 20'hB8003; m1_dat = 16'h0003; m1_we = 1'b1; m1_byte = 1'b1; m1_stb = 1'b1;
        s_ack_rr = 1'b1;
        s_ack_fp = 1'b1;
        s_dat_in = 16'h1111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (gnt !== exp_rr[i]) begin
                failures++;
                $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", i, gnt, exp_rr[i]);
            end
            checks++;
            if ({fp_gnt, fp_m1_ack} !== {exp_fp[i], 1'b0}) begin
                failures++;
                $display("FAIL fp_gnt cyc=%0d got=%b exp=%b", i, {fp_gnt, fp_m1_ack}, {exp_fp[i], 1'b0});
            end
            if (exp_rr[i] == 2'b10) begin
                checks++;
                if ({s_adr, s_dat, s_we, s_byte, m1_ack, m0_ack} !== {20'hB8003, 16'h0003, 4'b1110}) begin
                    failures++;
                    $display("FAIL rr_m1_write got=%h exp=%h", {s_adr, s_dat, s_we, s_byte, m1_ack, m0_ack},
                             {20'hB8003, 16'h0003, 4'b1110});
                end
            end
            cyc();
        end
        clear_inputs();
        cyc();
    endtask

    task automatic test_timeout();
        logic [1:0] expg;
        logic       expe;
        do_reset();
        m1_adr = 20'h00010;
        m1_stb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            expg = (i >= 1 && i <= 4) ? 2'b10 : 2'b00;
            expe = (i == 4);
            checks++;
            if ({gnt, m1_err, m0_err, m1_ack} !== {expg, expe, 2'b00}) begin
                failures++;
                $display("FAIL timeout cyc=%0d got=%b exp=%b", i, {gnt, m1_err, m0_err, m1_ack}, {expg, expe, 2'b00});
            end
            cyc();
            if (i == 4) m1_stb = 1'b0;
        end
        m0_adr = 20'h0ABCD;
        m0_stb = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b00) begin
            failures++;
            $display("FAIL after_to_idle got=%b exp=00", gnt);
        end
        cyc();
        s_ack_rr = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt, m0_ack, m0_err, s_adr} !== {2'b01, 2'b10, 20'h0ABCD}) begin
            failures++;
            $display("FAIL after_to_m0 got=%h exp=%h", {gnt, m0_ack, m0_err, s_adr}, {2'b01, 2'b10, 20'h0ABCD});
        end
        cyc();
        clear_inputs();
        cyc();
    endtask

    task automatic test_abort();
        do_reset();
        m0_adr = 20'h12340;
        m0_stb = 1'b1;
        @(negedge clk);
        cyc();
        @(negedge clk);
        checks++;
        if ({gnt, s_stb} !== 3'b011) begin
            failures++;
            $display("FAIL abort_busy got=%b exp=011", {gnt, s_stb});
        end
        cyc();
        m0_stb = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt, s_stb, m0_ack} !== 4'b0100) begin
            failures++;
            $display("FAIL abort_drop got=%b exp=0100", {gnt, s_stb, m0_ack});
        end
        cyc();
        s_ack_rr = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt, s_stb, m0_ack, m1_ack} !== 5'b00000) begin
            failures++;
            $display("FAIL abort_late_ack got=%b exp=00000", {gnt, s_stb, m0_ack, m1_ack});
        end
        cyc();
        s_ack_rr = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt, m0_ack} !== 3'b000) begin
            failures++;
            $display("FAIL abort_stays_idle got=%b exp=000", {gnt, m0_ack});
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m1_adr = 20'h2468A;
        m1_stb = 1'b1;
        @(negedge clk);
        cyc();
        @(negedge clk);
        checks++;
        if (gnt !== 2'b10) begin
            failures++;
            $display("FAIL mid_busy1 got=%b exp=10", gnt);
        end
        cyc();
        rst = 1'b1;
        s_ack_rr = 1'b1;
        @(negedge clk);
        checks++;
        if ({m0_ack, m1_ack, m0_err, m1_err, s_stb} !== 5'b00000) begin
            failures++;
            $display("FAIL mid_rst_cycle got=%b exp=00000", {m0_ack, m1_ack, m0_err, m1_err, s_stb});
        end
        cyc();
        rst = 1'b0;
        s_ack_rr = 1'b0;
        m0_stb = 1'b1;
        m0_adr = 20'h13579;
        @(negedge clk);
        checks++;
        if ({gnt, s_stb, m1_ack, m1_err} !== 5'b00000) begin
            failures++;
            $display("FAIL mid_after_rst got=%b exp=00000", {gnt, s_stb, m1_ack, m1_err});
        end
        cyc();
        @(negedge clk);
        checks++;
        if ({gnt, s_adr} !== {2'b01, 20'h13579}) begin
            failures++;
            $display("FAIL mid_tie_to_m0 got=%h exp=%h", {gnt, s_adr}, {2'b01, 20'h13579});
        end
        cyc();
        clear_inputs();
        cyc();
    endtask

    // Transaction-level reference: owner (-1 idle), cycles spent busy, and
    // which master was served most recently.
    task automatic test_random();
        int owner;
        int cnt;
        int pick;
        bit last;
        bit done0, done1;
        bit stbk;
        logic [6:0]  got_v, exp_v;
        logic [37:0] got_s, exp_s;
        do_reset();
        owner = -1;
        cnt = 0;
        last = 1'b1;
        done0 = 1'b0;
        done1 = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (!m0_stb) begin
                if ($urandom_range(0, 2) == 0) begin
                    m0_stb = 1'b1; m0_adr = 20'($urandom); m0_dat = 16'($urandom);
                    m0_we = 1'($urandom); m0_byte = 1'($urandom);
                end
            end else if (done0) begin
                if ($urandom_range(0, 1) == 0) m0_stb = 1'b0;
                else begin
                    m0_adr = 20'($urandom); m0_dat = 16'($urandom);
                    m0_we = 1'($urandom); m0_byte = 1'($urandom);
                end
            end else if ($urandom_range(0, 19) == 0) m0_stb = 1'b0;
            if (!m1_stb) begin
                if ($urandom_range(0, 2) == 0) begin
                    m1_stb = 1'b1; m1_adr = 20'($urandom); m1_dat = 16'($urandom);
                    m1_we = 1'($urandom); m1_byte = 1'($urandom);
                end
            end else if (done1) begin
                if ($urandom_range(0, 1) == 0) m1_stb = 1'b0;
                else begin
                    m1_adr = 20'($urandom); m1_dat = 16'($urandom);
                    m1_we = 1'($urandom); m1_byte = 1'($urandom);
                end
            end else if ($urandom_range(0, 19) == 0) m1_stb = 1'b0;
            s_ack_rr = ($urandom_range(0, 3) == 0);
            s_dat_in = 16'($urandom);

            @(negedge clk);
            exp_v = 7'b0;
            stbk = 1'b0;
            if (!rst && owner >= 0) begin
                stbk = (owner == 1) ? m1_stb : m0_stb;
                exp_v[6:5] = (owner == 1) ? 2'b10 : 2'b01;
                exp_v[4] = stbk;
                if (s_ack_rr) exp_v[owner == 0 ? 3 : 2] = 1'b1;
                else if (stbk && cnt == TO - 1) exp_v[owner == 0 ? 1 : 0] = 1'b1;
            end
            got_v = {gnt, s_stb, m0_ack, m1_ack, m0_err, m1_err};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL rand_ctrl n=%0d got=%b exp=%b", n, got_v, exp_v);
            end
            if (!rst && owner >= 0) begin
                got_s = {s_adr, s_dat, s_we, s_byte};
                exp_s = (owner == 1) ? {m1_adr, m1_dat, m1_we, m1_byte} : {m0_adr, m0_dat, m0_we, m0_byte};
                checks++;
                if (got_s !== exp_s) begin
                    failures++;
                    $display("FAIL rand_slave_port n=%0d got=%h exp=%h", n, got_s, exp_s);
                end
            end
            checks++;
            if (m_dat !== s_dat_in) begin
                failures++;
                $display("FAIL rand_rdata n=%0d got=%h exp=%h", n, m_dat, s_dat_in);
            end
            done0 = exp_v[3] | exp_v[1];
            done1 = exp_v[2] | exp_v[0];

            if (rst) begin
                owner = -1; cnt = 0; last = 1'b1;
            end else if (owner < 0) begin
                pick = -1;
                if (m0_stb && m1_stb) pick = last ? 0 : 1;
                else if (m0_stb) pick = 0;
                else if (m1_stb) pick = 1;
                if (pick >= 0) begin
                    owner = pick; last = (pick == 1); cnt = 0;
                end
            end else begin
                if (s_ack_rr || !stbk || cnt == TO - 1) owner = -1;
                else cnt++;
            end
            cyc();
        end
        rst = 1'b0;
        clear_inputs();
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_arbiter.md
Name: mem_wb_arbiter

Overview:
- Two-master arbiter that shares the single-slave memory map port (RAM/ROM/video, 20-bit byte address, 16-bit data, byte/word select) between master 0 (CPU) and master 1 (DMA/test sequencer).
- Grants one master at a time and holds the grant until the slave acks.
- Round-robin or fixed-priority selection.
- Bus watchdog: returns an error pulse to the requester when the slave never acks, so a stalled slave cannot hang the system.

Parameters:
- PRIORITY, 0, 0 = round-robin between masters; 1 = fixed priority, master 0 always wins simultaneous requests.
- TO_CYCLES, 255, slave cycles allowed in BUSY before timeout; range 1..2^TO_W-1.
- TO_W, 8, watchdog counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- m0_adr_i  in  20  master 0 byte address
- m0_dat_i  in  16  master 0 write data
- m0_we_i  in  1  master 0 write enable
- m0_byte_i  in  1  master 0 byte access (1) / word access (0)
- m0_stb_i  in  1  master 0 request strobe
- m0_ack_o  out  1  master 0 transfer acknowledge
- m0_err_o  out  1  master 0 timeout error pulse
- m1_adr_i / m1_dat_i / m1_we_i / m1_byte_i / m1_stb_i  in  20/16/1/1/1  master 1, same meaning as master 0
- m1_ack_o  out  1  master 1 transfer acknowledge
- m1_err_o  out  1  master 1 timeout error pulse
- m_dat_o  out  16  read data to both masters; equals s_dat_i; valid only with that master's ack
- s_adr_o  out  20  slave address
- s_dat_o  out  16  slave write data
- s_we_o  out  1  slave write enable
- s_byte_o  out  1  slave byte select
- s_stb_o  out  1  slave strobe
- s_ack_i  in  1  slave acknowledge
- gnt_o  out  2  one-hot current grant (debug/LCD); 00 when idle

Behaviour:
- States: IDLE, BUSY0, BUSY1. Registers: state, last (last granted master), wd (TO_W-bit watchdog counter).
- Reset values: state=IDLE, last=1 (so master 0 wins the first round-robin tie), wd=0.
- Outputs while in IDLE or reset:
  - s_stb_o=0, gnt_o=00, all ack and err outputs 0.
  - s_adr_o/s_dat_o/s_we_o/s_byte_o driven from master 0 but don't-care; s_we_o forced 0.
- IDLE transitions (evaluated on each clk):
  - Only m0_stb_i high -> BUSY0.
  - Only m1_stb_i high -> BUSY1.
  - Both high: PRIORITY=1 -> BUSY0; PRIORITY=0 -> BUSY(1-last).
  - Neither high -> stay IDLE.
  - On entering BUSYk: wd<=0, last<=k.
- BUSYk outputs:
  - Slave address/data/we/byte are combinational copies of master k's inputs.
  - s_stb_o = mk_stb_i; gnt_o bit k = 1.
  - mk_ack_o = s_ack_i (combinational); the other master's ack is 0.
- BUSYk exits:
  - s_ack_i=1 -> IDLE.
  - mk_stb_i=0 (master abort) -> IDLE, no ack forwarded; a late s_ack_i in IDLE is ignored.
  - No ack and wd==TO_CYCLES-1 -> mk_err_o=1 for exactly this cycle, then IDLE.
  - Otherwise wd<=wd+1.
- Latency: request is seen in IDLE; s_stb_o rises the next cycle; master ack comes in the same cycle as the slave ack.
- Every transaction is followed by at least one IDLE cycle (arbitration bubble). A master holding stb with a new address after its ack is re-arbitrated in that cycle.
- Round-robin guarantee: with both masters requesting continuously, grants alternate 0,1,0,1. A master waits at most one foreign transaction plus its bubble (≤ TO_CYCLES+2 cycles).
- Ack and timeout in the same cycle: the ack wins and err stays 0.
- The non-granted master's inputs are never visible on the slave port.
- Reset mid-transaction: the next edge forces IDLE, s_stb_o=0, and no ack or err is generated.

Test Plan:
- Single m0 word read, adr=C0004, slave acks 2 cycles after s_stb_o with 0A0B -> s_stb_o high for 3 cycles, m0_ack_o for 1 cycle with m_dat_o=0A0B, gnt_o=01, m1_ack_o stays 0.
- Both masters strobe continuously, PRIORITY=0, slave acks in the first cycle -> gnt_o sequence 01,00,10,00,01,...; m1 byte write adr=B8003 dat=0003 appears with s_byte_o=1, s_we_o=1.
- Same stimulus with PRIORITY=1 -> every grant is 01; m1 never granted while m0_stb_i is held.
- m1 request adr=00010, slave never acks, TO_CYCLES=4 -> m1_err_o single pulse on the 4th BUSY1 cycle, then IDLE; subsequent m0 request granted normally.
- m0 drops stb in the 2nd BUSY0 cycle -> s_stb_o falls the same cycle, state IDLE next edge, no m0_ack_o; slave ack arriving one cycle later is ignored.
- rst asserted during BUSY1 -> next cycle gnt_o=00, s_stb_o=0, no ack or err; after release, a tie is granted to master 0.
